pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, 32, PC width in bits.
REQ-002 Parameter RESET_VEC, 32'h8000_0000 (XLEN-sized), first fetch address after reset.
REQ-003 Parameter IALIGN, 4, instruction alignment and sequential increment in bytes; legal values 2 or 4.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 trap_en  input  1  trap redirect request.
REQ-007 trap_pc  input  XLEN  trap target.
REQ-008 ret_en  input  1  trap-return redirect request.
REQ-009 ret_pc  input  XLEN  trap-return target.
REQ-010 jump_en  input  1  branch/jump redirect request.
REQ-011 jump_pc  input  XLEN  branch/jump target.
REQ-012 stall  input  1  backend stall; suppresses pc_valid.
REQ-013 halt_req  input  1  enter HALT (ebreak/end of simulation).
REQ-014 ifu_ready  input  1  IFU accepts pc this cycle.
REQ-015 pc_valid  output  1  pc is a valid fetch request.
REQ-016 pc  output  XLEN  current fetch address.
REQ-017 misalign  output  1  one-cycle pulse: rejected misaligned redirect.
REQ-018 halted  output  1  block is in HALT.

Function
REQ-019 The FSM SHALL have the states BOOT, RUN and HALT, and SHALL enter BOOT on reset.
REQ-020 BOOT SHALL last exactly one cycle with pc_valid=0, then move to RUN with pc=RESET_VEC.
REQ-021 In RUN, pc_valid SHALL equal !stall; a fetch SHALL fire when pc_valid && ifu_ready.
REQ-022 On a fire with no redirect, pc SHALL become pc+IALIGN, computed modulo 2^XLEN (0xFFFF_FFFC+4 -> 0x0000_0000).
REQ-023 Redirect priority SHALL be trap_en > ret_en > jump_en; only the winner has effect.
REQ-024 A redirect in RUN SHALL load its target into pc the next cycle, regardless of ifu_ready and stall.
REQ-025 The low log2(IALIGN) bits of trap_pc SHALL be forced to zero; trap redirects are never misaligned.
REQ-026 A winning ret/jump target with nonzero low log2(IALIGN) bits SHALL be discarded: pc holds and misalign pulses for exactly one cycle.
REQ-027 Without a fire or an accepted redirect, pc SHALL hold its value, and pc SHALL stay stable while pc_valid && !ifu_ready.
REQ-028 halt_req in RUN, when no trap_en is present, SHALL move the FSM to HALT next cycle with pc held; trap_en in the same cycle SHALL win over halt_req.
REQ-029 In HALT: pc_valid=0 and halted=1; ret_en, jump_en and halt_req SHALL be ignored; trap_en SHALL return the FSM to RUN with pc=aligned trap_pc.
REQ-030 Redirects and halt_req received in BOOT SHALL be ignored.

Reset
REQ-031 When rst=1 at a rising edge: state=BOOT, pc=RESET_VEC, pc_valid=0, misalign=0, halted=0.
REQ-032 rst SHALL override every other input, including mid-redirect and HALT.

Structure
REQ-033 A shared package pc_gen_pkg SHALL hold the FSM state enum and the default RESET_VEC and IALIGN constants.
REQ-034 The priority selection and misalignment check SHALL be one combinational sub-module, pc_gen_redirect_arb, with outputs redir_valid, redir_pc and redir_misalign.

Verification
REQ-035 Reset then ifu_ready=1 for 3 cycles -> BOOT cycle with pc_valid=0, then pc=0x8000_0000, 0x8000_0004, 0x8000_0008.
REQ-036 trap_en (trap_pc=0x8000_0103), ret_en and jump_en all asserted in one cycle -> pc=0x8000_0100 next cycle, misalign=0.
REQ-037 jump_en with jump_pc=0x8000_0022 and IALIGN=4 -> misalign pulses one cycle and pc unchanged; with IALIGN=2 -> pc=0x8000_0022.
REQ-038 pc=0x8000_0010 with stall=1 and ifu_ready=0 for 2 cycles -> pc_valid=0 and pc held; stall plus jump_pc=0x8000_0200 -> pc=0x8000_0200.
REQ-039 halt_req at pc=0x8000_0040 -> halted=1, pc_valid=0, jump ignored; then trap_pc=0x8000_1000 -> RUN with pc=0x8000_1000.
REQ-040 pc=0xFFFF_FFFC with a fire -> pc=0x0000_0000; rst asserted while HALT -> BOOT and pc=RESET_VEC.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator.
//   pc_state_e       : FSM state encoding (boot, run, halt)
//   DefaultResetVec  : default first fetch address after reset
//   DefaultIalign    : default instruction alignment / sequential step in bytes
package pc_gen_pkg;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } pc_state_e;

  localparam logic [31:0] DefaultResetVec = 32'h8000_0000;
  localparam int unsigned DefaultIalign   = 4;

endpackage

// File: rtl/pc_gen_redirect_arb.sv
// Redirect arbiter: picks one redirect (trap > ret > jump) and checks its alignment.
//   trap_en/trap_pc  : trap request; target low bits are forced to zero, never misaligned
//   ret_en/ret_pc    : trap-return request
//   jump_en/jump_pc  : branch/jump request
//   redir_valid      : winning redirect is accepted
//   redir_pc         : target of the accepted redirect
//   redir_misalign   : winning ret/jump target is misaligned and must be discarded
module pc_gen_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = DefaultIalign
) (
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            ret_en,
  input  logic [XLEN-1:0] ret_pc,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_pc,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic            redir_misalign
);

  // IALIGN is a power of two, so IALIGN-1 covers exactly the offset bits.
  logic [XLEN-1:0] low_mask;
  assign low_mask = XLEN'(IALIGN - 1);

  always_comb begin
    redir_valid    = 1'b0;
    redir_pc       = '0;
    redir_misalign = 1'b0;
    if (trap_en) begin
      redir_valid = 1'b1;
      redir_pc    = trap_pc & ~low_mask;
    end else if (ret_en) begin
      if ((ret_pc & low_mask) != '0) begin
        redir_misalign = 1'b1;
      end else begin
        redir_valid = 1'b1;
        redir_pc    = ret_pc;
      end
    end else if (jump_en) begin
      if ((jump_pc & low_mask) != '0) begin
        redir_misalign = 1'b1;
      end else begin
        redir_valid = 1'b1;
        redir_pc    = jump_pc;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the instruction fetch unit.
//   clk, rst          : clock and synchronous active-high reset
//   trap_en/trap_pc   : trap redirect (highest priority, also leaves halt)
//   ret_en/ret_pc     : trap-return redirect
//   jump_en/jump_pc   : branch/jump redirect
//   stall             : backend stall, suppresses pc_valid
//   halt_req          : request to enter halt
//   ifu_ready         : fetch unit accepts pc this cycle
//   pc_valid, pc      : fetch request and its address
//   misalign          : one-cycle pulse after a discarded misaligned redirect
//   halted            : block is halted
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DefaultResetVec),
  parameter int unsigned     IALIGN    = DefaultIalign
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            ret_en,
  input  logic [XLEN-1:0] ret_pc,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_pc,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            ifu_ready,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc,
  output logic            misalign,
  output logic            halted
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;

  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            redir_misalign;
  logic            fire;

  pc_gen_redirect_arb #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_arb (
    .trap_en        (trap_en),
    .trap_pc        (trap_pc),
    .ret_en         (ret_en),
    .ret_pc         (ret_pc),
    .jump_en        (jump_en),
    .jump_pc        (jump_pc),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .redir_misalign (redir_misalign)
  );

  assign pc_valid = (state_q == StRun) && !stall;
  assign fire     = pc_valid && ifu_ready;
  assign pc       = pc_q;
  assign misalign = misalign_q;
  assign halted   = (state_q == StHalt);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StBoot: begin
        // Redirects and halt requests are ignored during the boot cycle.
        state_d = StRun;
        pc_d    = RESET_VEC;
      end
      StRun: begin
        if (halt_req && !trap_en) begin
          state_d = StHalt;
        end else if (redir_valid) begin
          pc_d = redir_pc;
        end else if (redir_misalign) begin
          misalign_d = 1'b1;
        end else if (fire) begin
          pc_d = pc_q + XLEN'(IALIGN);
        end
      end
      StHalt: begin
        // Only a trap wakes the block; the arbiter gives trap top priority.
        if (trap_en) begin
          state_d = StRun;
          pc_d    = redir_pc;
        end
      end
      default: begin
        state_d = StBoot;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        trap_en, ret_en, jump_en;
  logic [31:0] trap_pc, ret_pc, jump_pc;
  logic        stall, halt_req, ifu_ready;

  logic        pc_valid, misalign, halted;
  logic [31:0] pc;
  logic        pc_valid2, misalign2, halted2;
  logic [31:0] pc2;

  int tests;
  int fails;

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h8000_0000),
    .IALIGN    (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .trap_en   (trap_en),
    .trap_pc   (trap_pc),
    .ret_en    (ret_en),
    .ret_pc    (ret_pc),
    .jump_en   (jump_en),
    .jump_pc   (jump_pc),
    .stall     (stall),
    .halt_req  (halt_req),
    .ifu_ready (ifu_ready),
    .pc_valid  (pc_valid),
    .pc        (pc),
    .misalign  (misalign),
    .halted    (halted)
  );

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h8000_0000),
    .IALIGN    (2)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .trap_en   (trap_en),
    .trap_pc   (trap_pc),
    .ret_en    (ret_en),
    .ret_pc    (ret_pc),
    .jump_en   (jump_en),
    .jump_pc   (jump_pc),
    .stall     (stall),
    .halt_req  (halt_req),
    .ifu_ready (ifu_ready),
    .pc_valid  (pc_valid2),
    .pc        (pc2),
    .misalign  (misalign2),
    .halted    (halted2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trap_en = 1'b0; trap_pc = '0;
    ret_en  = 1'b0; ret_pc  = '0;
    jump_en = 1'b0; jump_pc = '0;
    stall = 1'b0; halt_req = 1'b0; ifu_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);

    // Boot cycle then sequential fetch
    rst = 1'b0; ifu_ready = 1'b1;
    #1;
    check("boot_valid", {31'd0, pc_valid}, 32'd0);
    tick();
    check("seq0_pc", pc, 32'h8000_0000);
    check("seq0_valid", {31'd0, pc_valid}, 32'd1);
    tick();
    check("seq1_pc", pc, 32'h8000_0004);
    check("seq1_pc2", pc2, 32'h8000_0002);
    tick();
    check("seq2_pc", pc, 32'h8000_0008);
    check("seq2_pc2", pc2, 32'h8000_0004);

    // Trap beats ret and jump; trap target aligned down
    trap_en = 1'b1; trap_pc = 32'h8000_0103;
    ret_en  = 1'b1; ret_pc  = 32'h8000_0200;
    jump_en = 1'b1; jump_pc = 32'h8000_0300;
    tick();
    check("trap_pc", pc, 32'h8000_0100);
    check("trap_pc2", pc2, 32'h8000_0102);
    check("trap_misalign", {31'd0, misalign}, 32'd0);

    // Misaligned jump: rejected at IALIGN=4, taken at IALIGN=2
    idle();
    jump_en = 1'b1; jump_pc = 32'h8000_0022;
    tick();
    check("mis_pc", pc, 32'h8000_0100);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_pc2", pc2, 32'h8000_0022);
    check("mis_pulse2", {31'd0, misalign2}, 32'd0);
    idle();
    tick();
    check("mis_end", {31'd0, misalign}, 32'd0);
    check("mis_hold", pc, 32'h8000_0100);

    // Stall holds pc and drops pc_valid; redirect still taken under stall
    jump_en = 1'b1; jump_pc = 32'h8000_0010;
    tick();
    check("j10_pc", pc, 32'h8000_0010);
    idle();
    stall = 1'b1;
    tick();
    check("stall0_valid", {31'd0, pc_valid}, 32'd0);
    check("stall0_pc", pc, 32'h8000_0010);
    tick();
    check("stall1_pc", pc, 32'h8000_0010);
    jump_en = 1'b1; jump_pc = 32'h8000_0200;
    tick();
    check("stall_jump_pc", pc, 32'h8000_0200);
    jump_en = 1'b0; ifu_ready = 1'b1;
    tick();
    check("stall_rdy_pc", pc, 32'h8000_0200);

    // Halt: jumps ignored, trap resumes
    idle();
    jump_en = 1'b1; jump_pc = 32'h8000_0040;
    tick();
    check("j40_valid", {31'd0, pc_valid}, 32'd1);
    idle();
    halt_req = 1'b1;
    tick();
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, pc_valid}, 32'd0);
    check("halt_pc", pc, 32'h8000_0040);
    halt_req = 1'b0; jump_en = 1'b1; jump_pc = 32'h8000_0300; ifu_ready = 1'b1;
    tick();
    check("halt_ign_pc", pc, 32'h8000_0040);
    check("halt_ign_halted", {31'd0, halted}, 32'd1);
    idle();
    trap_en = 1'b1; trap_pc = 32'h8000_1000;
    tick();
    check("wake_halted", {31'd0, halted}, 32'd0);
    check("wake_pc", pc, 32'h8000_1000);
    check("wake_valid", {31'd0, pc_valid}, 32'd1);
    trap_pc = 32'h8000_2000; halt_req = 1'b1;
    tick();
    check("trap_vs_halt_pc", pc, 32'h8000_2000);
    check("trap_vs_halt_halted", {31'd0, halted}, 32'd0);

    // Wrap-around on increment
    idle();
    jump_en = 1'b1; jump_pc = 32'hFFFF_FFFC;
    tick();
    check("top_pc", pc, 32'hFFFF_FFFC);
    idle();
    ifu_ready = 1'b1;
    tick();
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_pc2", pc2, 32'hFFFF_FFFE);

    // ret beats jump; misaligned winning ret blocks the jump
    idle();
    ret_en = 1'b1; ret_pc = 32'h8000_0500;
    jump_en = 1'b1; jump_pc = 32'h8000_0600;
    tick();
    check("ret_pc", pc, 32'h8000_0500);
    ret_pc = 32'h8000_0502;
    tick();
    check("ret_mis_pc", pc, 32'h8000_0500);
    check("ret_mis_pulse", {31'd0, misalign}, 32'd1);
    check("ret_mis_pc2", pc2, 32'h8000_0502);

    // Reset while halted; boot cycle ignores redirects and halt
    idle();
    halt_req = 1'b1;
    tick();
    check("halt2_halted", {31'd0, halted}, 32'd1);
    rst = 1'b1; trap_en = 1'b1; trap_pc = 32'h8000_3000;
    tick();
    check("rst_halt_pc", pc, 32'h8000_0000);
    check("rst_halt_halted", {31'd0, halted}, 32'd0);
    check("rst_halt_valid", {31'd0, pc_valid}, 32'd0);
    idle();
    rst = 1'b0;
    jump_en = 1'b1; jump_pc = 32'h8000_0700; halt_req = 1'b1; ifu_ready = 1'b1;
    tick();
    check("boot_ign_pc", pc, 32'h8000_0000);
    check("boot_ign_halted", {31'd0, halted}, 32'd0);
    check("boot_ign_valid", {31'd0, pc_valid}, 32'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
